// File: rtl/button_events.sv
// button_events: turns successive button frames into press/release/repeat events
// queued in a first-word-fall-through FIFO. Auto-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_events #(
  parameter int BUTTONS      = 8,
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic                         SYSCLK,
  input  logic                         NSYSRESET,
  input  logic                         ready,
  input  logic [BUTTONS-1:0]           buttonData,
  output logic [BUTTONS-1:0]           state,
  output logic                         evt_valid,
  output logic [2+$clog2(BUTTONS)-1:0] evt_data,
  input  logic                         evt_ready,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int IW = $clog2(BUTTONS);
  localparam int EW = 2 + IW;
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]    KIND_REPEAT = 2'b11;
  localparam logic [IW-1:0] LAST_IDX    = IW'(BUTTONS - 1);

  typedef enum logic {IDLE, SCAN} fsm_t;

  fsm_t               r_fsm;
  fsm_t               w_fsm_next;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx_next;
  logic               w_load;

  logic [BUTTONS-1:0] r_cur;
  logic [BUTTONS-1:0] r_prev;
  logic [BUTTONS-1:0] r_state;
  logic [BUTTONS-1:0] r_pend_data;
  logic               r_pend_valid;

  logic               w_frame_avail;
  logic [BUTTONS-1:0] w_frame;
  logic               w_last;
  logic               w_rep_due;

  logic [BUTTONS-1:0] w_btn_push;
  logic [1:0]         w_btn_kind [BUTTONS];
  logic               w_push;
  logic [EW-1:0]      w_push_data;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic               r_overflow;

  // A frame arriving in the same cycle as the pending one is newer, so it wins.
  assign w_frame_avail = ready | r_pend_valid;
  assign w_frame       = ready ? buttonData : r_pend_data;
  assign w_last        = (r_idx == LAST_IDX);

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_fsm <= IDLE;
      r_idx <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      r_idx <= w_idx_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_idx_next = r_idx;
    w_load     = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_frame_avail) begin
          w_load     = 1'b1;
          w_fsm_next = SCAN;
          w_idx_next = '0;
        end
      end
      SCAN: begin
        if (w_last) begin
          w_idx_next = '0;
          if (w_frame_avail) begin
            w_load = 1'b1;
          end else begin
            w_fsm_next = IDLE;
          end
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_cur        <= '0;
      r_prev       <= '0;
      r_state      <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_load) begin
      r_cur        <= w_frame;
      r_prev       <= r_state;
      r_state      <= w_frame;
      r_pend_valid <= 1'b0;
    end else if (ready) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= buttonData;
    end
  end

`ifdef BUTTON_REPEAT_EN
  logic [7:0] r_rep_cnt;
  logic [7:0] w_rep_cnt_inc;
  logic       r_rep_due;

  // The due flag is decided when a frame is accepted and holds for its whole scan.
  assign w_rep_cnt_inc = ((w_frame != r_state) || (w_frame == '0)) ? 8'd0 : r_rep_cnt + 8'd1;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_rep_cnt <= 8'd0;
      r_rep_due <= 1'b0;
    end else if (w_load) begin
      if (w_rep_cnt_inc == 8'(REPEAT_DELAY)) begin
        r_rep_due <= 1'b1;
        r_rep_cnt <= 8'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        r_rep_due <= 1'b0;
        r_rep_cnt <= w_rep_cnt_inc;
      end
    end
  end

  assign w_rep_due = r_rep_due;
`else
  assign w_rep_due = 1'b0;
`endif

  // Per-button event candidate; a change takes precedence over a repeat.
  generate
    for (genvar gi = 0; gi < BUTTONS; gi++) begin : g_btn
      assign w_btn_push[gi] = (r_cur[gi] ^ r_prev[gi]) | (w_rep_due & r_cur[gi]);
      assign w_btn_kind[gi] = (r_cur[gi] ^ r_prev[gi]) ? {1'b0, r_cur[gi]} : KIND_REPEAT;
    end
  endgenerate

  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (r_fsm == SCAN) begin
      w_push      = w_btn_push[r_idx];
      w_push_data = {w_btn_kind[r_idx], r_idx};
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge SYSCLK) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign state     = r_state;
  assign evt_valid = !w_empty;
  assign evt_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: timing, change events, overflow, pending frames,
// auto-repeat (expectations follow BUTTON_REPEAT_EN) and asynchronous reset.
module tb_button_events;

  localparam int BUTTONS = 8;
  localparam int DEPTH   = 8;
  localparam int IW      = $clog2(BUTTONS);
  localparam int EW      = 2 + IW;

  logic               SYSCLK = 1'b0;
  logic               NSYSRESET = 1'b0;
  logic               ready = 1'b0;
  logic [BUTTONS-1:0] buttonData = '0;
  logic               evt_ready = 1'b0;
  logic               clr_overflow = 1'b0;
  logic [BUTTONS-1:0] state;
  logic               evt_valid;
  logic [EW-1:0]      evt_data;
  logic               overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] got_q[$];
  logic [EW-1:0] exp_q[$];

  always #5 SYSCLK = ~SYSCLK;

  button_events #(
    .BUTTONS(BUTTONS), .DEPTH(DEPTH), .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .ready(ready), .buttonData(buttonData),
    .state(state), .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  // Record every pop, sampled mid-cycle.
  always @(negedge SYSCLK) begin
    if (NSYSRESET && evt_valid && evt_ready) begin
      got_q.push_back(evt_data);
      $display("[%0t] pop kind=%b idx=%0d", $time, evt_data[EW-1:IW], evt_data[IW-1:0]);
    end
  end

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input int idx);
    return {kind, IW'(idx)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cmp_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_ev%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [BUTTONS-1:0] f);
    ready      = 1'b1;
    buttonData = f;
    tick();
    ready = 1'b0;
    tick(BUTTONS + 3);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_state", 32'(state), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_data", 32'(evt_data), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    tick(2);
    NSYSRESET = 1'b1;
    evt_ready = 1'b1;
    tick();

    // First frame 0x05: event latency from ready
    ready = 1'b1;
    buttonData = 8'h05;
    tick();
    ready = 1'b0;
    tick();
    check("c2_valid", 32'(evt_valid), 32'h1);
    check("c2_data", 32'(evt_data), 32'(ev(2'b01, 0)));
    tick();
    check("c3_valid", 32'(evt_valid), 32'h0);
    tick();
    check("c4_valid", 32'(evt_valid), 32'h1);
    check("c4_data", 32'(evt_data), 32'(ev(2'b01, 2)));
    tick(6);
    check("f05_state", 32'(state), 32'h05);
    check("f05_ovf", 32'(overflow), 32'h0);
    got_q.delete();

    // Release, then an identical frame
    exp_q.push_back(ev(2'b00, 0));
    send_frame(8'h04);
    cmp_events("f04");
    send_frame(8'h04);
    cmp_events("f04_same");

    // Overflow: fill 8 entries, drop the 9th
    exp_q.push_back(ev(2'b00, 2));
    send_frame(8'h00);
    cmp_events("f00");
    evt_ready = 1'b0;
    send_frame(8'hFF);
    check("full_ovf0", 32'(overflow), 32'h0);
    check("full_head", 32'(evt_data), 32'(ev(2'b01, 0)));
    send_frame(8'h7F);
    check("drop_ovf1", 32'(overflow), 32'h1);
    check("drop_head", 32'(evt_data), 32'(ev(2'b01, 0)));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_ovf", 32'(overflow), 32'h0);

    // Push of idx 7 lands in cycle 8 together with a single pop
    ready = 1'b1;
    buttonData = 8'hFF;
    tick();
    ready = 1'b0;
    tick(7);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    got_q.delete();
    check("pp_ovf", 32'(overflow), 32'h0);
    check("pp_head", 32'(evt_data), 32'(ev(2'b01, 1)));
    evt_ready = 1'b1;
    tick(12);
    for (int i = 1; i < 8; i++) exp_q.push_back(ev(2'b01, i));
    exp_q.push_back(ev(2'b01, 7));
    cmp_events("pp_drain");

    // Pending buffer: second frame overwritten by the third
    send_frame(8'h00);
    got_q.delete();
    ready = 1'b1;
    buttonData = 8'h01;
    tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    buttonData = 8'h03;
    tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    buttonData = 8'h07;
    tick();
    ready = 1'b0;
    tick(20);
    exp_q.push_back(ev(2'b01, 0));
    exp_q.push_back(ev(2'b01, 1));
    exp_q.push_back(ev(2'b01, 2));
    cmp_events("pend");
    check("pend_state", 32'(state), 32'h07);

    // Hold button 1 for 8 frames
    send_frame(8'h00);
    got_q.delete();
    for (int f = 0; f < 8; f++) send_frame(8'h02);
    exp_q.push_back(ev(2'b01, 1));
`ifdef BUTTON_REPEAT_EN
    exp_q.push_back(ev(2'b11, 1));
    exp_q.push_back(ev(2'b11, 1));
    exp_q.push_back(ev(2'b11, 1));
`endif
    cmp_events("hold");
    check("hold_state", 32'(state), 32'h02);

    // Asynchronous reset mid-scan with 3 events queued
    evt_ready = 1'b0;
    ready = 1'b1;
    buttonData = 8'h0D;
    tick();
    ready = 1'b0;
    tick(3);
    check("pre_rst_valid", 32'(evt_valid), 32'h1);
    check("pre_rst_head", 32'(evt_data), 32'(ev(2'b01, 0)));
    #2;
    NSYSRESET = 1'b0;
    #1;
    check("arst_valid", 32'(evt_valid), 32'h0);
    check("arst_state", 32'(state), 32'h0);
    check("arst_data", 32'(evt_data), 32'h0);
    #2;
    NSYSRESET = 1'b1;
    tick(2);
    check("post_rst_valid", 32'(evt_valid), 32'h0);
    got_q.delete();
    evt_ready = 1'b1;
    send_frame(8'h00);
    cmp_events("post_rst");
    check("post_rst_state", 32'(state), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
